dmem_seq: RTL and testbench

- Sequencer and arbiter in front of the byte-wide data memory of the 16-bit core.
- Shares the single memory port between the core load/store unit and the debug/loader port, using 2-way round-robin.
- Splits 16-bit halfword accesses into two little-endian byte beats, assembles read data and applies sign/zero extension.
- Memory side: combinational read of the addressed byte; write on posedge when mem_we is high.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 38 +++
 rtl/dmem_seq.sv | 146 ++++++++++++++
 tb/tb_dmem_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory sequencer: FSM states, requester ids
// and the byte load extension helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_e;

    // Widen a loaded byte to 16 bits: zero-extend when uns, else sign-extend.
    function automatic logic [15:0] ext_byte(input logic [7:0] b, input logic uns);
        return {{8{b[7] & ~uns}}, b};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter. On a tie the requester that did not win
// last time is granted; the last-grant pointer moves only when update_i is set.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    req_core_i,
    input  logic    req_dbg_i,
    input  logic    update_i,
    output logic    gnt_o,
    output req_id_e gnt_id_o
);

    req_id_e last_q, last_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        gnt_o    = req_core_i | req_dbg_i;
        gnt_id_o = REQ_CORE;
        if (req_core_i && req_dbg_i) begin
            gnt_id_o = (last_q == REQ_DBG) ? REQ_CORE : REQ_DBG;
        end else if (req_dbg_i) begin
            gnt_id_o = REQ_DBG;
        end
        last_d = (update_i && gnt_o) ? gnt_id_o : last_q;
    end

    // Pointer starts at debug so the core wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_DBG;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_seq.sv
// Sequencer/arbiter for the byte-wide data memory: shares one memory port
// between the core LSU and the debug port, splitting halfwords into two beats.
module dmem_seq
    import dmem_pkg::*;
#(
    parameter int SIZE = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            core_req,
    input  logic            core_we,
    input  logic            core_half,
    input  logic            core_uns,
    input  logic [SIZE-1:0] core_addr,
    input  logic [15:0]     core_wdata,
    output logic            core_ack,
    output logic [15:0]     core_rdata,
    input  logic            dbg_req,
    input  logic            dbg_we,
    input  logic [SIZE-1:0] dbg_addr,
    input  logic [7:0]      dbg_wdata,
    output logic            dbg_ack,
    output logic [7:0]      dbg_rdata,
    output logic            mem_we,
    output logic [SIZE-1:0] mem_addr,
    output logic [7:0]      mem_wdata,
    input  logic [7:0]      mem_rdata,
    output logic            busy
);

    localparam logic [SIZE-1:0] ADDR_ONE = {{(SIZE-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    req_id_e         id_q;
    logic            we_q, half_q, uns_q;
    logic [SIZE-1:0] addr_q, mem_addr_q;
    logic [15:0]     wdata_q, rbuf_q, core_rdata_q;
    logic [7:0]      mem_wdata_q, dbg_rdata_q;
    logic            gnt;
    req_id_e         gnt_id;

    rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_core_i (core_req),
        .req_dbg_i  (dbg_req),
        .update_i   (state_q == IDLE),
        .gnt_o      (gnt),
        .gnt_id_o   (gnt_id)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt) state_d = BEAT0;
            BEAT0:   state_d = half_q ? BEAT1 : RESP;
            BEAT1:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory controls are decoded from state so a reset drops mem_we at once.
    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
        core_ack   = 1'b0;
        dbg_ack    = 1'b0;
        core_rdata = core_rdata_q;
        dbg_rdata  = dbg_rdata_q;
        busy       = (state_q != IDLE);
        case (state_q)
            BEAT0: begin
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q[7:0];
            end
            BEAT1: begin
                mem_we    = we_q;
                mem_addr  = addr_q + ADDR_ONE;
                mem_wdata = wdata_q[15:8];
            end
            RESP: begin
                if (id_q == REQ_CORE) begin
                    core_ack   = 1'b1;
                    core_rdata = half_q ? rbuf_q : ext_byte(rbuf_q[7:0], uns_q);
                end else begin
                    dbg_ack   = 1'b1;
                    dbg_rdata = rbuf_q[7:0];
                end
            end
            default: ;
        endcase
    end

    // Hold registers track the outputs so they keep their last value outside beats/RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q         <= REQ_CORE;
            we_q         <= 1'b0;
            half_q       <= 1'b0;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            if (state_q == IDLE && gnt) begin
                id_q <= gnt_id;
                if (gnt_id == REQ_CORE) begin
                    we_q    <= core_we;
                    half_q  <= core_half;
                    uns_q   <= core_uns;
                    addr_q  <= core_addr;
                    wdata_q <= core_wdata;
                end else begin
                    we_q    <= dbg_we;
                    half_q  <= 1'b0;
                    uns_q   <= 1'b1;
                    addr_q  <= dbg_addr;
                    wdata_q <= {8'h00, dbg_wdata};
                end
            end
            if (state_q == BEAT0) rbuf_q[7:0]  <= mem_rdata;
            if (state_q == BEAT1) rbuf_q[15:8] <= mem_rdata;
            mem_addr_q   <= mem_addr;
            mem_wdata_q  <= mem_wdata;
            core_rdata_q <= core_rdata;
            dbg_rdata_q  <= dbg_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_seq.sv
// Self-checking bench for dmem_seq: directed cases plus randomized traffic
// checked against a byte-array reference memory and a last-winner model.
module tb_dmem_seq;

    localparam int SIZE  = 11;
    localparam int DEPTH = 2 ** SIZE;
    localparam int BOUND = 20;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            core_req, core_we, core_half, core_uns;
    logic [SIZE-1:0] core_addr;
    logic [15:0]     core_wdata;
    logic            core_ack;
    logic [15:0]     core_rdata;
    logic            dbg_req, dbg_we;
    logic [SIZE-1:0] dbg_addr;
    logic [7:0]      dbg_wdata;
    logic            dbg_ack;
    logic [7:0]      dbg_rdata;
    logic            mem_we;
    logic [SIZE-1:0] mem_addr;
    logic [7:0]      mem_wdata;
    logic [7:0]      mem_rdata;
    logic            busy;

    dmem_seq #(.SIZE(SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_half  (core_half),
        .core_uns   (core_uns),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Physical memory driven by the DUT, plus a log of every write beat.
    logic [7:0]  mem [DEPTH];
    logic [18:0] wlog [$];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    always @(negedge clk) if (mem_we) wlog.push_back({mem_addr, mem_wdata});

    // Reference model: expected memory contents and who won the last grant.
    logic [7:0] ref_mem [DEPTH];
    bit         last_dbg;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_load(input bit half, input bit uns, input int a);
        logic [7:0] lo, hi;
        lo = ref_mem[a % DEPTH];
        hi = ref_mem[(a + 1) % DEPTH];
        if (half) return {hi, lo};
        if (uns) return {8'h00, lo};
        return 16'($signed(lo));
    endfunction

    task automatic model_store(input bit half, input int a, input logic [15:0] w);
        ref_mem[a % DEPTH] = w[7:0];
        if (half) ref_mem[(a + 1) % DEPTH] = w[15:8];
    endtask

    function automatic logic [SIZE-1:0] pick_addr();
        if ($urandom_range(0, 9) == 0) return SIZE'(DEPTH - 1);
        return SIZE'(16 + $urandom_range(0, 16));
    endfunction

    task automatic core_op(input bit we, input bit half, input bit uns, input logic [SIZE-1:0] addr,
                           input logic [15:0] wdata, output logic [15:0] rdata);
        int lat, wbase;
        logic [15:0] exp;
        @(posedge clk); #1;
        core_we = we; core_half = half; core_uns = uns; core_addr = addr; core_wdata = wdata;
        core_req = 1'b1;
        wbase = wlog.size();
        exp = model_load(half, uns, int'(addr));
        for (lat = 0; lat < BOUND; lat++) begin
            @(negedge clk);
            check("core_op_dbg_ack", 32'(dbg_ack), 32'd0);
            if (core_ack) break;
        end
        check("core_lat", 32'(lat), half ? 32'd3 : 32'd2);
        rdata = core_rdata;
        if (!we) check("core_rdata", 32'(rdata), 32'(exp));
        check("core_wbeats", 32'(wlog.size() - wbase), we ? (half ? 32'd2 : 32'd1) : 32'd0);
        if (we) model_store(half, int'(addr), wdata);
        last_dbg = 1'b0;
        @(posedge clk); #1;
        core_req = 1'b0;
    endtask

    task automatic dbg_op(input bit we, input logic [SIZE-1:0] addr, input logic [7:0] wdata,
                          output logic [7:0] rdata);
        int lat, wbase;
        logic [7:0] exp;
        @(posedge clk); #1;
        dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        dbg_req = 1'b1;
        wbase = wlog.size();
        exp = ref_mem[int'(addr)];
        for (lat = 0; lat < BOUND; lat++) begin
            @(negedge clk);
            check("dbg_op_core_ack", 32'(core_ack), 32'd0);
            if (dbg_ack) break;
        end
        check("dbg_lat", 32'(lat), 32'd2);
        rdata = dbg_rdata;
        if (!we) check("dbg_rdata", 32'(rdata), 32'(exp));
        check("dbg_wbeats", 32'(wlog.size() - wbase), we ? 32'd1 : 32'd0);
        if (we) model_store(1'b0, int'(addr), {8'h00, wdata});
        last_dbg = 1'b1;
        @(posedge clk); #1;
        dbg_req = 1'b0;
    endtask

    // Both requesters hold byte reads high for n completions; the model
    // predicts who wins each tie from the previous winner.
    task automatic tie_run(input int n, output bit order [$]);
        logic [SIZE-1:0] ca, da;
        bit cu, exp_dbg;
        int gap;
        ca = pick_addr(); da = pick_addr(); cu = 1'($urandom_range(0, 1));
        order.delete();
        @(posedge clk); #1;
        core_we = 1'b0; core_half = 1'b0; core_uns = cu; core_addr = ca; core_wdata = 16'h0;
        dbg_we = 1'b0; dbg_addr = da; dbg_wdata = 8'h0;
        core_req = 1'b1; dbg_req = 1'b1;
        for (int k = 0; k < n; k++) begin
            for (gap = 0; gap < BOUND; gap++) begin
                @(negedge clk);
                if (core_ack || dbg_ack) break;
            end
            check("tie_lat", 32'(gap), 32'd2);
            exp_dbg = !last_dbg;
            check("tie_core_ack", 32'(core_ack), 32'(!exp_dbg));
            check("tie_dbg_ack", 32'(dbg_ack), 32'(exp_dbg));
            if (exp_dbg) check("tie_dbg_rdata", 32'(dbg_rdata), 32'(ref_mem[int'(da)]));
            else         check("tie_core_rdata", 32'(core_rdata), 32'(model_load(1'b0, cu, int'(ca))));
            order.push_back(dbg_ack);
            last_dbg = exp_dbg;
        end
        @(posedge clk); #1;
        core_req = 1'b0; dbg_req = 1'b0;
    endtask

    initial begin
        logic [15:0] rd16;
        logic [7:0]  rd8;
        bit          order [$];
        int          wbase;
        logic [SIZE-1:0] ra;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        rst_n = 1'b0; last_dbg = 1'b1;
        core_req = 0; core_we = 0; core_half = 0; core_uns = 0; core_addr = '0; core_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_acks", 32'({core_ack, dbg_ack}), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_rdata", 32'({core_rdata, dbg_rdata}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Known contents for every address the random traffic can touch.
        for (int a = 16; a <= 32; a += 2) core_op(1, 1, 0, SIZE'(a), 16'($urandom), rd16);

        core_op(1, 0, 0, SIZE'(16), 16'h00A5, rd16);
        core_op(0, 0, 0, SIZE'(16), 16'h0, rd16);
        check("byte_sext_a5", 32'(rd16), 32'hFFA5);

        wbase = wlog.size();
        core_op(1, 1, 0, SIZE'(DEPTH - 1), 16'h1234, rd16);
        check("wrap_beat0", 32'(wlog[wbase]), 32'({11'h7FF, 8'h34}));
        check("wrap_beat1", 32'(wlog[wbase + 1]), 32'({11'h000, 8'h12}));
        core_op(0, 1, 0, SIZE'(DEPTH - 1), 16'h0, rd16);
        check("wrap_load", 32'(rd16), 32'h1234);

        core_op(1, 0, 0, SIZE'(20), 16'h0080, rd16);
        core_op(0, 0, 1, SIZE'(20), 16'h0, rd16);
        check("byte_zext_80", 32'(rd16), 32'h0080);
        core_op(0, 0, 0, SIZE'(20), 16'h0, rd16);
        check("byte_sext_80", 32'(rd16), 32'hFF80);

        dbg_op(1, SIZE'(12'h123), 8'h5C, rd8);
        dbg_op(0, SIZE'(12'h123), 8'h00, rd8);
        check("dbg_read_123", 32'(rd8), 32'h5C);

        // Reset in BEAT1 of a halfword store: low byte may land, high byte must not.
        ra = SIZE'(24);
        @(posedge clk); #1;
        core_we = 1; core_half = 1; core_uns = 0; core_addr = ra; core_wdata = 16'hBEEF;
        core_req = 1'b1;
        repeat (3) @(negedge clk);
        check("beat1_busy", 32'(busy), 32'd1);
        check("beat1_mem_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(core_ack), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_rdata", 32'({core_rdata, dbg_rdata}), 32'd0);
        core_req = 1'b0;
        model_store(1'b0, int'(ra), 16'h00EF);
        last_dbg = 1'b1;
        @(posedge clk); #1;
        check("abort_high_byte", 32'(mem[int'(ra) + 1]), 32'(ref_mem[int'(ra) + 1]));
        @(negedge clk);
        rst_n = 1'b1;

        tie_run(4, order);
        check("tie_order", 32'({order[0], order[1], order[2], order[3]}), 32'b0101);
        core_op(0, 1, 0, ra, 16'h0, rd16);

        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 4))
                0, 1: core_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), pick_addr(), 16'($urandom), rd16);
                2, 3: dbg_op(1'($urandom_range(0, 1)), pick_addr(), 8'($urandom), rd8);
                default: tie_run($urandom_range(2, 4), order);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
